// File: rtl/cc_encoder_rr_pkg.sv
// Shared constants, state encoding and code mapping for the round-robin
// request encoder and the selection decoder that consumes its code.
package cc_encoder_rr_pkg;

  localparam int DATAWIDTH_ENCODER_IN  = 12;
  localparam int DATAWIDTH_ENCODER_OUT = 4;

  localparam int NUM_LINES = DATAWIDTH_ENCODER_IN;
  localparam int CODE_W    = DATAWIDTH_ENCODER_OUT;

  localparam logic [CODE_W-1:0] CODE_NONE = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Line index 0..NUM_LINES-1 maps to code 1..NUM_LINES; code 0 means none.
  function automatic logic [CODE_W-1:0] idx_to_code(input logic [CODE_W-1:0] idx);
    return idx + CODE_W'(1);
  endfunction

  // Priority pointer after granting a code: the line just above the winner,
  // wrapping from the last line back to line 0.
  function automatic logic [CODE_W-1:0] ptr_after(input logic [CODE_W-1:0] code);
    return (code >= CODE_W'(NUM_LINES)) ? '0 : code;
  endfunction

endpackage

// File: rtl/cc_encoder_rr_if.sv
// Request/grant bus between the request sources, the encoder and the
// consumer of the granted code.
//
// Handshake: the encoder raises valid with code/grant/multi and holds all of
// them unchanged until a rising edge where valid and ready are both high;
// that edge is the transfer. ready is ignored while valid is low, and valid is
// never withdrawn without a transfer (only reset discards a pending grant).
interface cc_encoder_rr_if;
  import cc_encoder_rr_pkg::*;

  logic [NUM_LINES-1:0] CC_ENCODER_request_InBUS;
  logic                 CC_ENCODER_ready_In;
  logic [CODE_W-1:0]    CC_ENCODER_code_OutBUS;
  logic                 CC_ENCODER_valid_Out;
  logic [NUM_LINES-1:0] CC_ENCODER_grant_OutBUS;
  logic                 CC_ENCODER_multi_Out;

  // Requesters and consumer side.
  modport master (
    output CC_ENCODER_request_InBUS,
    output CC_ENCODER_ready_In,
    input  CC_ENCODER_code_OutBUS,
    input  CC_ENCODER_valid_Out,
    input  CC_ENCODER_grant_OutBUS,
    input  CC_ENCODER_multi_Out
  );

  // Encoder side.
  modport slave (
    input  CC_ENCODER_request_InBUS,
    input  CC_ENCODER_ready_In,
    output CC_ENCODER_code_OutBUS,
    output CC_ENCODER_valid_Out,
    output CC_ENCODER_grant_OutBUS,
    output CC_ENCODER_multi_Out
  );
endinterface

// File: rtl/cc_encoder_rr_pick.sv
// Circular first-set search: starting at eff_ptr and moving upward with
// wrap-around, report the first asserted request line.
module cc_rr_pick
  import cc_encoder_rr_pkg::*;
(
  input  logic [NUM_LINES-1:0] req_i,
  input  logic [CODE_W-1:0]    eff_ptr_i,
  output logic [CODE_W-1:0]    idx_o,
  output logic                 found_o
);

  logic [CODE_W:0] pos;

  // Walk all lines once in priority order; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      pos = {1'b0, eff_ptr_i} + (CODE_W+1)'(k);
      if (pos >= (CODE_W+1)'(NUM_LINES)) begin
        pos = pos - (CODE_W+1)'(NUM_LINES);
      end
      if (!found_o && req_i[pos[CODE_W-1:0]]) begin
        idx_o   = pos[CODE_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_encoder_rr.sv
// Round-robin request encoder: grants one of the request lines and presents
// its code (1..NUM_LINES) under valid/ready, rotating priority past each
// accepted winner.
module cc_encoder_rr
  import cc_encoder_rr_pkg::*;
(
  input  logic                 CC_ENCODER_CLOCK_50,
  input  logic                 CC_ENCODER_RESET_InHigh,
  cc_encoder_rr_if.slave       bus,
  output state_e               dbg_state_o,
  output logic [CODE_W-1:0]    dbg_ptr_o
);

  state_e               state_q, state_d;
  logic [CODE_W-1:0]    ptr_q, ptr_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [NUM_LINES-1:0] grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic                 multi_q, multi_d;

  logic                 handshake;
  logic [CODE_W-1:0]    eff_ptr;
  logic [CODE_W-1:0]    pick_idx;
  logic                 pick_found;
  logic                 req_multi;

  // On a transfer the search starts just past the outgoing winner, so the
  // back-to-back grant already honours the rotated priority.
  assign handshake = (state_q == ST_HOLD) && valid_q && bus.CC_ENCODER_ready_In;
  assign eff_ptr   = handshake ? ptr_after(code_q) : ptr_q;
  assign req_multi = ($countones(bus.CC_ENCODER_request_InBUS) > 1);

  cc_rr_pick u_pick (
    .req_i     (bus.CC_ENCODER_request_InBUS),
    .eff_ptr_i (eff_ptr),
    .idx_o     (pick_idx),
    .found_o   (pick_found)
  );

  // Next-state and next-output logic: load a grant from IDLE, freeze in HOLD
  // until the transfer, then reload or fall back to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    grant_d = grant_q;
    valid_d = valid_q;
    multi_d = multi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_HOLD;
          code_d  = idx_to_code(pick_idx);
          grant_d = NUM_LINES'(1) << pick_idx;
          valid_d = 1'b1;
          multi_d = req_multi;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          ptr_d = ptr_after(code_q);
          if (pick_found) begin
            code_d  = idx_to_code(pick_idx);
            grant_d = NUM_LINES'(1) << pick_idx;
            valid_d = 1'b1;
            multi_d = req_multi;
          end else begin
            state_d = ST_IDLE;
            code_d  = CODE_NONE;
            grant_d = '0;
            valid_d = 1'b0;
            multi_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset drops any
  // pending grant without a transfer.
  always_ff @(posedge CC_ENCODER_CLOCK_50) begin
    if (CC_ENCODER_RESET_InHigh) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      code_q  <= CODE_NONE;
      grant_q <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign bus.CC_ENCODER_code_OutBUS  = code_q;
  assign bus.CC_ENCODER_grant_OutBUS = grant_q;
  assign bus.CC_ENCODER_valid_Out    = valid_q;
  assign bus.CC_ENCODER_multi_Out    = multi_q;
  assign dbg_state_o                 = state_q;
  assign dbg_ptr_o                   = ptr_q;

endmodule
